// File: rtl/store_buffer_if.sv
// Bundle of the store-side, memory-side and load-hazard signals of the store buffer.
// The slave modport is the buffer itself and the master modport is whatever surrounds it.
interface store_buffer_if #(parameter int DEPTH = 4);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_addr;
  logic [31:0]   in_data;
  logic [3:0]    in_mask;

  logic          mem_valid;
  logic          mem_ready;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_data;
  logic [3:0]    mem_mask;

  logic [31:0]   ld_addr;
  logic          ld_hazard;
  logic [CW-1:0] count;
  logic          empty;

  modport master (
    output in_valid, in_addr, in_data, in_mask, mem_ready, ld_addr,
    input  in_ready, mem_valid, mem_addr, mem_data, mem_mask, ld_hazard, count, empty
  );

  modport slave (
    input  in_valid, in_addr, in_data, in_mask, mem_ready, ld_addr,
    output in_ready, mem_valid, mem_addr, mem_data, mem_mask, ld_hazard, count, empty
  );
endinterface

// File: rtl/store_buffer.sv
// In-order store buffer: a circular FIFO of {addr, data, mask} entries that drains to memory
// and flags loads that hit a word with a pending or incoming store.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  store_buffer_if.slave sb
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]      addr_mem [DEPTH];
  logic [31:0]      data_mem [DEPTH];
  logic [3:0]       mask_mem [DEPTH];
  logic [PW-1:0]    head_reg;
  logic [PW-1:0]    tail_reg;
  logic [CW-1:0]    count_reg;
  logic             push;
  logic             pop;
  logic [DEPTH-1:0] entry_hit;
  logic             in_hit;
  logic             unused_ld_bits;

  // Readiness only looks at occupancy, so a full buffer never accepts even while draining.
  assign sb.in_ready  = (count_reg != FULL) && !rst;
  assign sb.empty     = (count_reg == '0);
  assign sb.mem_valid = !sb.empty && !rst;
  assign sb.count     = count_reg;

  assign push = sb.in_valid && sb.in_ready && (sb.in_mask != 4'b0);
  assign pop  = sb.mem_valid && sb.mem_ready;

  assign sb.mem_addr = addr_mem[head_reg];
  assign sb.mem_data = data_mem[head_reg];
  assign sb.mem_mask = mask_mem[head_reg];

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) tail_reg <= tail_reg + 1'b1;
      if (pop)  head_reg <= head_reg + 1'b1;
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  // Payload storage carries no reset; every read is qualified by occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail_reg] <= sb.in_addr;
      data_mem[tail_reg] <= sb.in_data;
      mask_mem[tail_reg] <= sb.in_mask;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic occ_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        occ_reg <= 1'b0;
      end else if (push && (tail_reg == PW'(gi))) begin
        occ_reg <= 1'b1;
      end else if (pop && (head_reg == PW'(gi))) begin
        occ_reg <= 1'b0;
      end
    end

    assign entry_hit[gi] = occ_reg && (mask_mem[gi] != 4'b0) &&
                           (addr_mem[gi][31:2] == sb.ld_addr[31:2]);
  end

  assign in_hit = sb.in_valid && (sb.in_mask != 4'b0) &&
                  (sb.in_addr[31:2] == sb.ld_addr[31:2]);

  assign sb.ld_hazard = (|entry_hit) || in_hit;

  // Hazards are tracked at word granularity, so the byte offset of the load is irrelevant.
  assign unused_ld_bits = ^sb.ld_addr[1:0];
endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001: Parameter DEPTH, default 4, number of buffered store entries (power of two, >=2).
REQ-002: clk  input  1  single clock; all state updates on rising edge.
REQ-003: rst  input  1  synchronous, active-high reset.
REQ-004: in_valid  input  1  upstream store write controller presents a store this cycle.
REQ-005: in_ready  output  1  buffer can accept a store this cycle.
REQ-006: in_addr  input  32  store byte address (word-aligned use of [31:2]).
REQ-007: in_data  input  32  byte-lane-aligned store data.
REQ-008: in_mask  input  4  byte write-enable mask, bit i enables data[8i+7:8i].
REQ-009: mem_valid  output  1  head entry presented to memory port.
REQ-010: mem_ready  input  1  memory port accepts head entry this cycle.
REQ-011: mem_addr  output  32  head entry address.
REQ-012: mem_data  output  32  head entry data.
REQ-013: mem_mask  output  4  head entry mask.
REQ-014: ld_addr  input  32  address of the load currently in the memory stage.
REQ-015: ld_hazard  output  1  a pending or incoming store targets ld_addr's word.
REQ-016: count  output  $clog2(DEPTH)+1  number of occupied entries.
REQ-017: empty  output  1  count == 0.

Function
REQ-018: Storage SHALL be a circular FIFO of DEPTH entries {addr[31:0], data[31:0], mask[3:0]} with head/tail pointers wrapping modulo DEPTH.
REQ-019: in_ready SHALL equal (count != DEPTH) and not rst; it SHALL NOT depend on mem_ready (no pass-through when full).
REQ-020: Push occurs when in_valid && in_ready && in_mask != 0; entry written at tail, tail advances by 1.
REQ-021: in_valid && in_ready with in_mask == 0 SHALL be accepted and discarded (no entry, count unchanged).
REQ-022: Pop occurs when mem_valid && mem_ready; head advances by 1.
REQ-023: mem_valid SHALL equal !empty; mem_addr/mem_data/mem_mask SHALL be driven from the head entry registers only (no combinational bypass from in_*).
REQ-024: Push-to-mem_valid latency SHALL be exactly 1 cycle when the buffer is empty.
REQ-025: Simultaneous push and pop SHALL leave count unchanged; both pointers advance.
REQ-026: count SHALL be updated every cycle as count + push - pop and never exceed DEPTH or underflow.
REQ-027: mem_* outputs SHALL hold stable while mem_valid && !mem_ready.
REQ-028: ld_hazard SHALL be combinational: 1 if any occupied entry has addr[31:2] == ld_addr[31:2] and nonzero mask, or if in_valid && in_mask != 0 && in_addr[31:2] == ld_addr[31:2]; else 0.
REQ-029: Entries SHALL drain strictly in push order; no merging or reordering.

Reset
REQ-030: While rst is high at a rising edge: head, tail, count <= 0; mem_valid = 0, empty = 1, in_ready = 0 during rst, 1 the cycle after.
REQ-031: Reset mid-operation SHALL discard all pending entries; no pop is issued in the reset cycle even if mem_ready = 1.
REQ-032: Entry data registers need not be reset; outputs SHALL be qualified by mem_valid.

Verification
REQ-033: Push addr 0x1000_0004, data 0x0000_AB00, mask 0010, mem_ready=0 -> next cycle mem_valid=1, mem_addr=0x1000_0004, mem_mask=0010, count=1; outputs held 3 cycles; mem_ready=1 -> next cycle empty=1.
REQ-034: DEPTH pushes with mem_ready=0 -> count=DEPTH, in_ready=0; further in_valid ignored; then mem_ready=1 drains in push order, one per cycle.
REQ-035: Full buffer, in_valid=1 and mem_ready=1 same cycle -> push not taken, pop taken, count=DEPTH-1; next cycle in_ready=1.
REQ-036: Steady push+pop every cycle at count=2 across >2*DEPTH cycles -> count stays 2, pointer wrap-around preserves order.
REQ-037: Pending entry addr 0x1000_0008, ld_addr 0x1000_000B -> ld_hazard=1; ld_addr 0x1000_000C -> 0; in_mask=0000 store to 0x1000_000C -> ld_hazard=0, count unchanged.
REQ-038: Three entries pending, rst asserted 1 cycle with mem_ready=1 -> count=0, mem_valid=0, no mem transfer; next push visible after 1 cycle.
